// File: rtl/dpwm_cfg_if.sv
// dpwm_cfg_if: control/config bus and gate outputs of the DPWM core.
// The master side (controller or bench) drives run/fault and the period,
// duty and dead-time settings; the slave side (the core) returns the gates
// and status.
interface dpwm_cfg_if #(
    parameter int CNT_W = 10,
    parameter int DT_W  = 4
);
    logic             en;
    logic             fault;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] duty;
    logic [DT_W-1:0]  dt1;
    logic [DT_W-1:0]  dt2;
    logic             hs;
    logic             ls;
    logic             wrap;
    logic             ss_done;
    logic             faulted;

    modport master (
        output en, fault, period, duty, dt1, dt2,
        input  hs, ls, wrap, ss_done, faulted
    );

    modport slave (
        input  en, fault, period, duty, dt1, dt2,
        output hs, ls, wrap, ss_done, faulted
    );
endinterface

// File: rtl/dpwm_cfg_core.sv
// dpwm_cfg_core: complementary digital PWM with per-edge dead time,
// shadowed period/duty/dead-time registers and a latched fault shutdown.
// Optional feature macro: DPWM_SOFTSTART_EN adds the SOFT state, which ramps
// the effective duty by one count per period up to the programmed duty.
// Without it the block enters RUN directly at the full duty.
module dpwm_cfg_core #(
    parameter int CNT_W = 10,
    parameter int DT_W  = 4
) (
    input logic       clk,
    input logic       resetn,
    dpwm_cfg_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
`ifdef DPWM_SOFTSTART_EN
        , ST_SOFT = 2'd3
`endif
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W:0]   EXT_ONE = (CNT_W+1)'(1);
    localparam logic [DT_W-1:0]  DT_ONE  = DT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   duty_eff_q, duty_eff_d;
    logic [CNT_W-1:0] p_sh_q, p_sh_d;
    logic [CNT_W:0]   d_sh_q, d_sh_d;
    logic [DT_W-1:0]  dt1_sh_q, dt1_sh_d;
    logic [DT_W-1:0]  dt2_sh_q, dt2_sh_d;
    logic [DT_W-1:0]  dtc1_q, dtc1_d;
    logic [DT_W-1:0]  dtc2_q, dtc2_d;
    logic             hs_q, hs_d;
    logic             ls_q, ls_d;

    logic             active;
    logic             wrap_w;
    logic             hs_raw;
    logic [CNT_W:0]   period_p1;
    logic [CNT_W:0]   d_clamp;
`ifdef DPWM_SOFTSTART_EN
    logic [CNT_W:0]   ramp;
`endif

    // Carrier status and duty clamp; period+1 needs one extra bit so a
    // full-period duty is representable at the maximum period.
    always_comb begin
`ifdef DPWM_SOFTSTART_EN
        active = (state_q == ST_RUN) || (state_q == ST_SOFT);
`else
        active = (state_q == ST_RUN);
`endif
        wrap_w    = active && (cnt_q >= p_sh_q);
        hs_raw    = ({1'b0, cnt_q} < duty_eff_q);
        period_p1 = {1'b0, bus.period} + EXT_ONE;
        d_clamp   = ({1'b0, bus.duty} > period_p1) ? period_p1 : {1'b0, bus.duty};
    end

    // State transitions, carrier advance and shadow reloads; fault wins over all.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        duty_eff_d = duty_eff_q;
        p_sh_d     = p_sh_q;
        d_sh_d     = d_sh_q;
        dt1_sh_d   = dt1_sh_q;
        dt2_sh_d   = dt2_sh_q;
`ifdef DPWM_SOFTSTART_EN
        ramp       = duty_eff_q + EXT_ONE;
`endif
        if (bus.fault) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.en) begin
                        p_sh_d   = bus.period;
                        d_sh_d   = d_clamp;
                        dt1_sh_d = bus.dt1;
                        dt2_sh_d = bus.dt2;
`ifdef DPWM_SOFTSTART_EN
                        state_d    = ST_SOFT;
                        duty_eff_d = '0;
`else
                        state_d    = ST_RUN;
                        duty_eff_d = d_clamp;
`endif
                    end
                end
                ST_FAULT: begin
                    if (!bus.en) state_d = ST_IDLE;
                end
                default: begin
                    if (!bus.en) begin
                        state_d = ST_IDLE;
                    end else if (wrap_w) begin
                        cnt_d    = '0;
                        p_sh_d   = bus.period;
                        d_sh_d   = d_clamp;
                        dt1_sh_d = bus.dt1;
                        dt2_sh_d = bus.dt2;
`ifdef DPWM_SOFTSTART_EN
                        if (state_q == ST_SOFT) begin
                            duty_eff_d = (ramp < d_clamp) ? ramp : d_clamp;
                            if (duty_eff_d == d_clamp) state_d = ST_RUN;
                        end else begin
                            duty_eff_d = d_clamp;
                        end
`else
                        duty_eff_d = d_clamp;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            endcase
        end
        // The carrier only runs while switching.
        if (state_d == ST_IDLE || state_d == ST_FAULT) cnt_d = '0;
    end

    // Dead-time counters and gate decode. Both gates come from one raw compare
    // bit, so they can never overlap, even across reloads or state changes.
    always_comb begin
        dtc1_d = '0;
        dtc2_d = '0;
        hs_d   = 1'b0;
        ls_d   = 1'b0;
        if (active && hs_raw) begin
            hs_d   = (dtc1_q >= dt1_sh_q);
            dtc1_d = hs_d ? dt1_sh_q : dtc1_q + DT_ONE;
        end
        if (active && !hs_raw) begin
            ls_d   = (dtc2_q >= dt2_sh_q);
            dtc2_d = ls_d ? dt2_sh_q : dtc2_q + DT_ONE;
        end
    end

    // State, carrier, shadows and registered gates; reset drops gates at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            duty_eff_q <= '0;
            p_sh_q     <= '0;
            d_sh_q     <= '0;
            dt1_sh_q   <= '0;
            dt2_sh_q   <= '0;
            dtc1_q     <= '0;
            dtc2_q     <= '0;
            hs_q       <= 1'b0;
            ls_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            duty_eff_q <= duty_eff_d;
            p_sh_q     <= p_sh_d;
            d_sh_q     <= d_sh_d;
            dt1_sh_q   <= dt1_sh_d;
            dt2_sh_q   <= dt2_sh_d;
            dtc1_q     <= dtc1_d;
            dtc2_q     <= dtc2_d;
            hs_q       <= hs_d;
            ls_q       <= ls_d;
        end
    end

    assign bus.hs      = hs_q;
    assign bus.ls      = ls_q;
    assign bus.wrap    = wrap_w;
    assign bus.ss_done = (state_q == ST_RUN);
    assign bus.faulted = (state_q == ST_FAULT);
endmodule
